// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan controller with a shared external decoder.
// Double-buffered digit/blank/dp state; shadow commits only at frame edges.
module seg7_scan_ctrl #(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [2:0]      wr_addr,
  input  logic [3:0]      wr_data,
  input  logic            wr_blank,
  input  logic            wr_dp,
  input  logic            upd_req,
  output logic            upd_ack,
  output logic            frame_start,
  output logic [3:0]      dec_b,
  input  logic [7:0]      dec_h,
  output logic [7:0]      seg,
  output logic [NDIG-1:0] an
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] C_BEND = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] C_SEND = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NDIG - 1);
  localparam logic [3:0]    N4     = 4'(NDIG);

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t st, st_d;

  logic [IW-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          pend;

  logic [NDIG-1:0][3:0] sh_dat, ac_dat, nx_dat;
  logic [NDIG-1:0]      sh_blk, sh_dp;
  logic [NDIG-1:0]      ac_blk, ac_dp;

  logic wr_hit, wrap, commit;
  logic enter_blk, fstart_d;

  logic [NDIG-1:0] an_d;
  logic [7:0]      seg_d;
  logic            unused_dec_dp;

  assign unused_dec_dp = dec_h[0];

  assign wr_ready = ~pend;
  assign wr_hit   = wr_valid & ~pend
                  & ({1'b0, wr_addr} < N4);

  assign wrap = (st == S_SHOW) && en
             && (cnt == C_SEND)
             && (idx == I_LAST);

  // OFF commits straight away: nothing is on screen to tear
  assign commit = pend
               && (wrap || st == S_OFF);

  assign nx_dat = commit ? sh_dat : ac_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= S_OFF;
      idx <= '0;
      cnt <= '0;
    end else begin
      st  <= st_d;
      idx <= idx_d;
      cnt <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st;
    idx_d = idx;
    cnt_d = cnt + 1'b1;
    if (!en) begin
      st_d  = S_OFF;
      idx_d = '0;
      cnt_d = '0;
    end else begin
      unique case (st)
        S_OFF: begin
          st_d  = S_BLANK;
          idx_d = '0;
          cnt_d = '0;
        end
        S_BLANK: begin
          if (cnt == C_BEND)
            st_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt == C_SEND) begin
            st_d  = S_BLANK;
            cnt_d = '0;
            idx_d = (idx == I_LAST)
                  ? '0 : idx + 1'b1;
          end
        end
        default: begin
          st_d  = S_OFF;
          idx_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign enter_blk = (st_d == S_BLANK)
                  && (st != S_BLANK);
  assign fstart_d  = enter_blk
                  && (idx_d == '0);

  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (st == S_SHOW) begin
      if (!ac_blk[idx])
        an_d = ~(NDIG'(1) << idx);
      seg_d = {dec_h[7:1], ~ac_dp[idx]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= 1'b0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
      dec_b       <= '0;
      sh_dat      <= '0;
      sh_blk      <= '1;
      sh_dp       <= '0;
      ac_dat      <= '0;
      ac_blk      <= '1;
      ac_dp       <= '0;
    end else begin
      upd_ack     <= commit;
      frame_start <= fstart_d;
      if (wr_hit) begin
        sh_dat[wr_addr[IW-1:0]] <= wr_data;
        sh_blk[wr_addr[IW-1:0]] <= wr_blank;
        sh_dp[wr_addr[IW-1:0]]  <= wr_dp;
      end
      if (commit) begin
        ac_dat <= sh_dat;
        ac_blk <= sh_blk;
        ac_dp  <= sh_dp;
        pend   <= 1'b0;
      end else if (upd_req) begin
        pend <= 1'b1;
      end
      // digit 0 may load the value being committed this edge
      if (enter_blk)
        dec_b <= nx_dat[idx_d];
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: random traffic vs a
// time-based reference of the scan and commit rules.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = ND * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic       wr_dp;
  logic       upd_req;
  logic       upd_ack;
  logic       frame_start;
  logic [3:0] dec_b;
  logic [7:0] dec_h;
  logic [7:0] seg;
  logic [3:0] an;

  int npass = 0;
  int ntot  = 0;
  int acks  = 0;
  bit run   = 1'b0;

  seg7_scan_ctrl #(
    .NDIG(ND),
    .SCAN_DIV(SD),
    .BLANK_CYC(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_blank(wr_blank),
    .wr_dp(wr_dp),
    .upd_req(upd_req),
    .upd_ack(upd_ack),
    .frame_start(frame_start),
    .dec_b(dec_b),
    .dec_h(dec_h),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  // active-low {a..g, dp-off}
  function automatic logic [7:0] hexseg(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return {~s, 1'b1};
  endfunction

  assign dec_h = hexseg(dec_b);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h @%0t",
                  tag, got, exp, $time);
  endtask

  // reference: t counts cycles since the enabling edge
  int         t;
  bit         on, pend;
  logic [3:0] sd [ND];
  logic [3:0] ad [ND];
  bit         sb [ND], sp [ND];
  bit         ab [ND], ap [ND];
  logic [3:0] e_an;
  logic [7:0] e_seg;
  bit         e_ack, e_fs;
  bit         show_now;
  logic [3:0] e_decb;
  int         md, mph;
  bit         bnd, cmt;
  logic [7:0] mh;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; on = 0; pend = 0;
      for (int i = 0; i < ND; i++) begin
        sd[i] = 0; sb[i] = 1; sp[i] = 0;
        ad[i] = 0; ab[i] = 1; ap[i] = 0;
      end
      e_an = 4'hF; e_seg = 8'hFF;
      e_ack = 0; e_fs = 0;
      show_now = 0; e_decb = 0;
    end else begin
      md  = (t / SD) % ND;
      mph = t % SD;
      e_an = 4'hF; e_seg = 8'hFF;
      if (on && mph >= BC) begin
        if (!ab[md]) e_an = ~(4'b1 << md);
        mh = hexseg(ad[md]);
        e_seg = {mh[7:1], ~ap[md]};
      end
      bnd = on && en && (t == FR - 1);
      cmt = pend && (bnd || !on);
      e_ack = cmt;
      e_fs  = en && (bnd || !on);
      if (wr_valid && !pend && wr_addr < 3'(ND)) begin
        sd[wr_addr] = wr_data;
        sb[wr_addr] = wr_blank;
        sp[wr_addr] = wr_dp;
      end
      if (cmt) begin
        ad = sd; ab = sb; ap = sp;
        pend = 0;
      end else if (upd_req) begin
        pend = 1;
      end
      if (!en) begin on = 0; t = 0; end
      else if (!on) begin on = 1; t = 0; end
      else t = (t + 1) % FR;
      show_now = on && (t % SD) >= BC;
      e_decb = ad[(t / SD) % ND];
    end
  end

  always @(negedge clk) begin
    if (!rst && run) begin
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("ack", upd_ack, e_ack);
      chk("fs", frame_start, e_fs);
      chk("rdy", wr_ready, !pend);
      if (show_now) chk("decb", dec_b, e_decb);
    end
    if (!rst && upd_ack) acks++;
  end

  task automatic idle();
    wr_valid = 0; upd_req = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(
    input logic [2:0] a, input logic [3:0] d,
    input logic b, input logic p
  );
    wr_valid = 1; wr_addr = a; wr_data = d;
    wr_blank = b; wr_dp = p;
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    while (an !== v && n < 3 * FR) begin
      @(negedge clk); n++;
    end
    chk("wait_an", an, v);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!upd_ack && n < 3 * FR) begin
      @(negedge clk); n++;
    end
    chk("ack_seen", upd_ack, 1);
  endtask

  int a0;

  initial begin
    rst = 1; en = 0; wr_valid = 0; upd_req = 0;
    wr_addr = 0; wr_data = 0;
    wr_blank = 0; wr_dp = 0;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_decb", dec_b, 0);
    chk("rst_ack", upd_ack, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rdy", wr_ready, 1);
    cyc(2);
    rst = 0; en = 1; run = 1;
    cyc(2 * FR + 6);

    wr(0, 4'h1, 0, 0);
    wr(1, 4'h2, 0, 0);
    wr(2, 4'h3, 0, 1);
    wr(3, 4'hA, 0, 0);
    upd_req = 1;
    @(negedge clk);
    upd_req = 0;
    chk("rdy_low", wr_ready, 0);
    wait_ack();
    chk("ack_fs", frame_start, 1);
    wait_an(4'b1101);
    chk("dig1_seg", seg, 8'b00100101);
    wait_an(4'b1011);
    chk("dig2_seg", seg, 8'b00001100);

    while (!frame_start) @(negedge clk);
    a0 = acks;
    upd_req = 1;
    @(negedge clk);
    wr_valid = 1; wr_addr = 0; wr_data = 4'h7;
    wr_blank = 0; wr_dp = 0;
    cyc(2);
    idle();
    cyc(2 * FR);
    chk("one_ack", acks - a0, 1);
    wait_an(4'b1110);
    chk("no_late_wr", dec_b, 4'h1);

    wait_an(4'b1011);
    upd_req = 1;
    @(negedge clk);
    upd_req = 0; en = 0;
    @(negedge clk);
    chk("en_lag", an, 4'b1011);
    @(negedge clk);
    chk("en_dark", an, 4'hF);
    chk("en_ack", upd_ack, 1);
    cyc(3);
    en = 1;
    @(negedge clk);
    chk("re_fs", frame_start, 1);
    cyc(FR);

    wr(5, 4'hF, 1, 1);
    upd_req = 1;
    @(negedge clk);
    upd_req = 0;
    wait_ack();
    cyc(2 * FR);

    repeat (800) begin
      en       = ($urandom % 40) != 0;
      wr_valid = $urandom % 2;
      wr_addr  = 3'($urandom % 8);
      wr_data  = 4'($urandom);
      wr_blank = ($urandom % 4) == 0;
      wr_dp    = $urandom % 2;
      upd_req  = ($urandom % 16) == 0;
      @(negedge clk);
    end
    idle(); en = 1;
    cyc(FR + 5);

    upd_req = 1;
    @(negedge clk);
    upd_req = 0;
    a0 = acks;
    #2 rst = 1;
    #1;
    chk("mid_an", an, 4'hF);
    chk("mid_seg", seg, 8'hFF);
    chk("mid_ack", upd_ack, 0);
    chk("mid_rdy", wr_ready, 1);
    chk("mid_decb", dec_b, 0);
    @(negedge clk);
    rst = 0;
    cyc(2 * FR);
    chk("mid_noack", acks - a0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display. It shares a single external bcd7seg hex decoder across all digits. The block holds double-buffered digit, blank and dot registers, cycles one digit per slot with an anti-ghosting blank gap, and commits host updates only at frame boundaries so the display never tears. It sits between the host/register logic and the board's segment and anode pins.

Parameters:
NDIG, 8, number of digits scanned (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (blank gap included); must be > BLANK_CYC
BLANK_CYC, 16, cycles per slot with all anodes off (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable; 0 = display dark
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when wr_valid&&wr_ready
wr_addr  in  3  digit index
wr_data  in  4  hex nibble
wr_blank  in  1  1 = digit dark
wr_dp  in  1  1 = decimal point lit
upd_req  in  1  request commit of shadow to active
upd_ack  out  1  1-cycle pulse when commit applied
frame_start  out  1  1-cycle pulse on entry to digit 0 slot
dec_b  out  4  nibble to shared decoder (registered)
dec_h  in  8  decoder result, active-low, bit0 = dp
seg  out  8  segment pins, active-low, bit0 = dp (registered)
an  out  NDIG  anode selects, active-low one-hot (registered)

Behaviour:
- Reset (async, rst=1): an all 1, seg 8'hFF, dec_b 0, upd_ack 0, frame_start 0, wr_ready 1, state OFF, idx 0, slot counter 0. Shadow and active: data 0, blank all 1, dp 0. Commit-pending flag 0.
- State OFF (en=0): an all 1, seg FF, counter and idx held at 0. When en=1, go to BLANK with idx 0 and pulse frame_start.
- BLANK: an all 1, seg FF. dec_b = active_data[idx], loaded on entry. After BLANK_CYC cycles, go to SHOW.
- SHOW: an[idx]=0 and all other bits 1. If active_blank[idx]=1, an is all 1 instead. seg = {dec_h[7:1], ~active_dp[idx]}. After SCAN_DIV-BLANK_CYC cycles: idx wraps NDIG-1 -> 0 (frame boundary), otherwise idx+1, then go to BLANK.
- Slot length is exactly SCAN_DIV cycles; frame length is NDIG*SCAN_DIV cycles.
- an and seg are registered: the pins reflect state with 1 cycle of latency. dec_h is sampled in the cycle the SHOW outputs are computed; the decoder is combinational.
- en=0 in any state: the next state is OFF. Pins go dark on the following edge, and idx and counter reset.
- Writes:
  - Accepted when wr_valid&&wr_ready. The shadow entry at wr_addr is updated with data, blank and dp.
  - wr_addr >= NDIG: the write is accepted and discarded.
  - Active registers are never written directly.
- wr_ready = ~pending.
- Commit handshake:
  - upd_req=1 while pending=0 sets pending. A write accepted in the same cycle is included in the commit.
  - upd_req while pending=1 is ignored, with no extra ack.
  - Commit happens at the frame boundary edge (SHOW idx NDIG-1 -> BLANK idx 0), or on the next edge if state is OFF. On that edge all shadow is copied to active, upd_ack=1 for one cycle, and pending is cleared.
  - Frame boundary coincident with upd_req setting pending: the commit waits for the next boundary.
- frame_start pulses on the same edge as the commit (boundary or OFF->BLANK).
- rst asserted mid-frame or mid-commit: immediate return to reset values; pending is lost and no ack is issued.

Test Plan:
- NDIG=4, SCAN_DIV=8, BLANK_CYC=2, en=1 after reset -> an stays 4'b1111 (all active blank=1) and seg=FF; frame_start pulses every 32 cycles.
- Write {0:1,1:2,2:3,3:A}, all blank=0, dp on digit 2, then upd_req -> wr_ready=0 until upd_ack, which coincides with the next frame_start. Then each slot shows 2 cycles an=1111/seg=FF followed by 6 cycles of the digit's an and seg: digit 1 gives an=1101, seg=8'b00100101; digit 2 gives seg=8'b00001100.
- upd_req held high 3 cycles -> exactly one upd_ack; a write attempted while wr_ready=0 does not reach the display after the ack.
- en dropped mid-SHOW of digit 2 -> an=1111, seg=FF one cycle later. With pending=1, upd_ack fires the next cycle. Re-enabling starts at digit 0 with frame_start.
- Write to wr_addr=5 (NDIG=4) then commit -> the displayed values are unchanged.
- rst pulsed mid-frame with pending=1 -> outputs return to reset values asynchronously; no upd_ack; wr_ready=1.
